abacus_counter_bank: RTL and testbench
======================================

Name: abacus_counter_bank

Overview:
Parametrised, generic event-counter bank for the ABACUS profiler. Generalises the fixed instruction and cache counter sets into NUM_COUNTERS independent counters of COUNTER_WIDTH bits. Adds per-channel enables, freeze, clear-all, sticky overflow and optional atomic snapshot. Sits beside the core on the Wishbone bus; the core drives one event_inc bit per profiled event.

Parameters:
NUM_COUNTERS, 16, number of counter channels; legal 1..32
COUNTER_WIDTH, 48, bits per counter; legal 1..64
BASE_ADDR, 32'hf0030000, Wishbone base address; 4 KiB window
SATURATE, 1'b0, 0 = counter wraps to 0 at max; 1 = counter holds at max

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
event_inc  in  NUM_COUNTERS  bit i high = one event for counter i this cycle
wb_cyc  in  1  Wishbone cycle
wb_stb  in  1  Wishbone strobe
wb_we  in  1  Wishbone write enable
wb_adr  in  32  byte address; bits [1:0] ignored
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data; registered, valid with wb_ack
wb_ack  out  1  one-cycle acknowledge
ovf_any  out  1  OR of all sticky overflow bits; registered

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all counters = 0, CTRL = 0, CHAN_EN = 0, OVF = 0, snapshots = 0, wb_ack = 0, wb_dat_o = 0, ovf_any = 0. A reset mid-transaction drops wb_ack to 0 on the next edge. The master must retry.
- Register map, as offsets from BASE_ADDR:
  - 0x000 CTRL: bit0 global enable; bit1 freeze; bit2 snapshot pulse; bit3 clear-all pulse. Bits 2 and 3 self-clear and always read 0.
  - 0x004 CHAN_EN: bit i enables counter i; bits >= NUM_COUNTERS read 0.
  - 0x008 OVF: sticky overflow flags, write-1-to-clear.
  - 0x100 + 8*i: counter i bits [31:0].
  - 0x104 + 8*i: counter i bits [COUNTER_WIDTH-1:32], zero-extended; reads 0 when COUNTER_WIDTH <= 32.
  - Counter words are read-only; writes to them are acked and ignored.
  - Unmapped addresses, and counter indices >= NUM_COUNTERS, read 0 and are acked.
- Wishbone timing:
  - wb_ack is set to wb_cyc & wb_stb & ~wb_ack, giving exactly 1 cycle of latency.
  - A write commits on the cycle where wb_cyc & wb_stb & wb_we & ~wb_ack, once per transaction.
  - wb_dat_o is registered on that same cycle; it is 0 when the cycle is not a read.
- Counting:
  - Counter i increments by 1 when event_inc[i] & CHAN_EN[i] & CTRL.enable & ~CTRL.freeze.
  - Control writes take effect for events from the next cycle onward.
- Overflow:
  - An increment from all-ones sets OVF[i].
  - SATURATE=0: the counter wraps to 0.
  - SATURATE=1: the counter holds at all-ones.
- Simultaneous events:
  - Clear-all and an increment in the same cycle: the counter becomes 0, and OVF is not set by that increment.
  - Clear-all does not clear OVF.
  - An OVF W1C and a new overflow on the same bit in the same cycle: the bit stays 1 (set wins).
  - A write to CTRL or CHAN_EN alongside an event: the event uses the old register values.

Optional Feature:
ABACUS_COUNTER_SNAPSHOT_EN
- Defined: a snapshot-pulse write copies all live counters atomically into shadow registers on the commit edge. The copy holds the pre-increment value of that cycle. Counter-word reads return the shadow values. Clear-all also zeroes the shadows.
- Undefined: no shadow registers are built; the snapshot bit is ignored; counter-word reads return live values.

Test Plan:
- Reset, then read 0x000, 0x004, 0x008, 0x100 -> all 0; wb_ack high exactly 1 cycle after stb.
- CTRL=1, CHAN_EN=0x5, 10 pulses on all event_inc bits -> counter0 = 10, counter1 = 0, counter2 = 10.
- COUNTER_WIDTH=8, SATURATE=0, 257 events on ch0 -> counter0 = 1, OVF = 0x1, ovf_any = 1; write OVF = 0x1 -> reads 0.
- SATURATE=1, same stimulus -> counter0 = 0xFF, OVF bit0 = 1; clear-all with event in the same cycle -> counter0 = 0, OVF still 1.
- Freeze set mid-stream after 5 events, 5 more events -> counter = 5; clear freeze, 3 events -> 8.
- With the snapshot macro: count 20, snapshot, 7 more events -> read 20; snapshot again -> read 27. Without the macro: read 27 directly.

Source files
------------

// File: rtl/abacus_counter_bank.sv
// abacus_counter_bank: Wishbone-mapped bank of NUM_COUNTERS event counters, COUNTER_WIDTH bits each.
// Latency: wb_ack and wb_dat_o are registered, one cycle after cyc&stb; counters update on the edge that samples event_inc.
// Backpressure: none. Every strobe is acked once; counter words are read-only; unmapped words read 0.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   event_inc            one increment request per counter per cycle
//   wb_cyc/stb/we/adr    Wishbone slave request (byte address, bits [1:0] ignored)
//   wb_dat_i / wb_dat_o  write data / registered read data (0 on non-read cycles)
//   wb_ack               single-cycle acknowledge
//   ovf_any              registered OR of the sticky overflow flags
//
// Optional build macro ABACUS_COUNTER_SNAPSHOT_EN: adds shadow registers loaded by the CTRL
// snapshot pulse; counter-word reads then return the shadow copy instead of the live counter.
module abacus_counter_bank #(
   parameter int          NUM_COUNTERS  = 16,
   parameter int          COUNTER_WIDTH = 48,
   parameter logic [31:0] BASE_ADDR     = 32'hf0030000,
   parameter bit          SATURATE      = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_COUNTERS-1:0] event_inc,
   input  logic                    wb_cyc,
   input  logic                    wb_stb,
   input  logic                    wb_we,
   input  logic [31:0]             wb_adr,
   input  logic [31:0]             wb_dat_i,
   output logic [31:0]             wb_dat_o,
   output logic                    wb_ack,
   output logic                    ovf_any
);

   localparam int N  = NUM_COUNTERS;
   localparam int CW = COUNTER_WIDTH;

   logic                 ack_q, ack_d;
   logic [31:0]          dat_q, dat_d;
   logic                 ovf_any_q, ovf_any_d;
   logic                 ctrl_en_q, ctrl_en_d;
   logic                 ctrl_frz_q, ctrl_frz_d;
   logic [N-1:0]         chan_en_q, chan_en_d;
   logic [N-1:0]         ovf_q, ovf_d;
   logic [CW-1:0]        cnt_q [N];
   logic [CW-1:0]        cnt_d [N];
   logic [CW-1:0]        rd_src [N];

   // Request decode. The 4 KiB window is matched on the upper address bits only.
   logic                 access, in_win, wr, rd;
   logic [9:0]           word;
   logic                 wr_ctrl, wr_chan, wr_ovf;
   logic                 clr_all, snap_pulse;
   logic [N-1:0]         inc, ovf_set;

   assign access     = wb_cyc & wb_stb & ~ack_q;
   assign in_win     = (wb_adr[31:12] == BASE_ADDR[31:12]);
   assign word       = wb_adr[11:2];
   assign wr         = access & wb_we & in_win;
   assign rd         = access & ~wb_we;
   assign wr_ctrl    = wr & (word == 10'd0);
   assign wr_chan    = wr & (word == 10'd1);
   assign wr_ovf     = wr & (word == 10'd2);
   assign clr_all    = wr_ctrl & wb_dat_i[3];
   assign snap_pulse = wr_ctrl & wb_dat_i[2];

   // Qualifiers come from the registered control state, so a control write
   // in the same cycle as an event does not affect that event.
   assign inc = event_inc & chan_en_q & {N{ctrl_en_q & ~ctrl_frz_q}};

   always_comb begin
      ovf_set = '0;
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clr_all) begin
            // Clear-all beats a coincident increment and suppresses its overflow.
            cnt_d[i] = '0;
         end else if (inc[i]) begin
            if (&cnt_q[i]) begin
               ovf_set[i] = 1'b1;
               cnt_d[i]   = SATURATE ? cnt_q[i] : '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // W1C clear is applied before the new set so a coincident overflow survives.
   assign ovf_d      = (ovf_q & ~(wr_ovf ? wb_dat_i[N-1:0] : '0)) | ovf_set;
   assign ovf_any_d  = |ovf_d;
   assign chan_en_d  = wr_chan ? wb_dat_i[N-1:0] : chan_en_q;
   assign ctrl_en_d  = wr_ctrl ? wb_dat_i[0] : ctrl_en_q;
   assign ctrl_frz_d = wr_ctrl ? wb_dat_i[1] : ctrl_frz_q;
   assign ack_d      = wb_cyc & wb_stb & ~ack_q;

`ifdef ABACUS_COUNTER_SNAPSHOT_EN
   logic [CW-1:0] snap_q [N];

   // The copy takes cnt_q, i.e. the value before this cycle's increment.
   always_ff @(posedge clk) begin
      if (rst || clr_all) begin
         for (int i = 0; i < N; i++) snap_q[i] <= '0;
      end else if (snap_pulse) begin
         snap_q <= cnt_q;
      end
   end
   assign rd_src = snap_q;
`else
   assign rd_src = cnt_q;
`endif

   // Read mux. Counter words live at byte offsets 0x100..0x1FF: word[5:1] is the
   // channel, word[0] selects the upper half. Channels >= N never match and read 0.
   logic [CW-1:0] src;
   logic [63:0]   ext;
   logic [31:0]   rdata;

   always_comb begin
      src = '0;
      for (int i = 0; i < N; i++) begin
         if (word[5:1] == 5'(i)) src = rd_src[i];
      end
      ext   = 64'(src);
      rdata = '0;
      if (in_win) begin
         if (word == 10'd0)           rdata = {30'd0, ctrl_frz_q, ctrl_en_q};
         else if (word == 10'd1)      rdata = 32'(chan_en_q);
         else if (word == 10'd2)      rdata = 32'(ovf_q);
         else if (word[9:6] == 4'h1)  rdata = word[0] ? ext[63:32] : ext[31:0];
      end
      dat_d = rd ? rdata : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q      <= 1'b0;
         dat_q      <= '0;
         ovf_any_q  <= 1'b0;
         ctrl_en_q  <= 1'b0;
         ctrl_frz_q <= 1'b0;
         chan_en_q  <= '0;
         ovf_q      <= '0;
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      end else begin
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         ovf_any_q  <= ovf_any_d;
         ctrl_en_q  <= ctrl_en_d;
         ctrl_frz_q <= ctrl_frz_d;
         chan_en_q  <= chan_en_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
      end
   end

   assign wb_ack   = ack_q;
   assign wb_dat_o = dat_q;
   assign ovf_any  = ovf_any_q;

   // Low address bits, unused data bits and (without shadows) the snapshot pulse.
   logic unused_ok;
   assign unused_ok = ^{wb_adr[1:0], wb_dat_i, snap_pulse};

endmodule

// File: tb/tb_abacus_counter_bank.sv
module tb_abacus_counter_bank;

   localparam logic [31:0] B      = 32'hf0030000;
   localparam logic [31:0] A_CTRL = B;
   localparam logic [31:0] A_CHEN = B + 32'h4;
   localparam logic [31:0] A_OVF  = B + 32'h8;
   localparam logic [31:0] A_C0   = B + 32'h100;

   logic        clk, rst;
   logic        cyc  [2];
   logic        stb  [2];
   logic        we   [2];
   logic [31:0] adr  [2];
   logic [31:0] wdat [2];
   logic [31:0] rdat [2];
   logic        ack  [2];
   logic        ovf  [2];
   logic [3:0]  ev   [2];

   typedef struct {
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ma, mb;
   int   n_pass  = 0;
   int   n_total = 0;

   // dut0 wraps, dut1 saturates; both 4 channels of 8 bits.
   abacus_counter_bank #(.NUM_COUNTERS(4), .COUNTER_WIDTH(8), .BASE_ADDR(B), .SATURATE(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .event_inc(ev[0]),
      .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we[0]), .wb_adr(adr[0]), .wb_dat_i(wdat[0]),
      .wb_dat_o(rdat[0]), .wb_ack(ack[0]), .ovf_any(ovf[0]));

   abacus_counter_bank #(.NUM_COUNTERS(4), .COUNTER_WIDTH(8), .BASE_ADDR(B), .SATURATE(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .event_inc(ev[1]),
      .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we[1]), .wb_adr(adr[1]), .wb_dat_i(wdat[1]),
      .wb_dat_o(rdat[1]), .wb_ack(ack[1]), .ovf_any(ovf[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] e);
      n_total++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, e);
   endtask

   // Monitor: every ack pops one expected response (writes expect 0 on wb_dat_o).
   always @(negedge clk) begin
      if (ack[0]) begin
         if (qa.size() == 0) chk("dut0_unexpected_ack", 64'd1, 64'd0);
         else begin
            ma = qa.pop_front();
            chk(ma.name, 64'(rdat[0]), 64'(ma.exp));
         end
      end
      if (ack[1]) begin
         if (qb.size() == 0) chk("dut1_unexpected_ack", 64'd1, 64'd0);
         else begin
            mb = qb.pop_front();
            chk(mb.name, 64'(rdat[1]), 64'(mb.exp));
         end
      end
   end

   // One Wishbone transaction; evm drives event_inc only on the commit edge.
   task automatic wb_acc(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] e, input logic [3:0] evm, input string nm);
      int   n;
      exp_t x;
      @(posedge clk); #1;
      cyc[s] = 1'b1; stb[s] = 1'b1; we[s] = w; adr[s] = a; wdat[s] = d;
      if (evm != 4'd0) ev[s] = evm;
      x.exp  = w ? 32'd0 : e;
      x.name = nm;
      if (s == 0) qa.push_back(x); else qb.push_back(x);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ack[s] && n < 4);
      chk({nm, "_ack_latency"}, 64'(n), 64'd1);
      cyc[s] = 1'b0; stb[s] = 1'b0; we[s] = 1'b0;
      if (evm != 4'd0) ev[s] = 4'd0;
      @(posedge clk); #1;
      chk({nm, "_ack_drop"}, 64'(ack[s]), 64'd0);
   endtask

   task automatic wr(input int s, input logic [31:0] a, input logic [31:0] d, input string nm);
      wb_acc(s, 1'b1, a, d, 32'd0, 4'd0, nm);
   endtask

   task automatic wr_ev(input int s, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] evm, input string nm);
      wb_acc(s, 1'b1, a, d, 32'd0, evm, nm);
   endtask

   task automatic rd(input int s, input logic [31:0] a, input logic [31:0] e, input string nm);
      wb_acc(s, 1'b0, a, 32'd0, e, 4'd0, nm);
   endtask

   task automatic pulse(input int s, input logic [3:0] mask, input int n);
      @(posedge clk); #1;
      ev[s] = mask;
      repeat (n) @(posedge clk);
      #1;
      ev[s] = 4'd0;
   endtask

   // With shadow registers, counter reads need a fresh snapshot first.
   task automatic snap(input int s, input logic [31:0] base);
`ifdef ABACUS_COUNTER_SNAPSHOT_EN
      wr(s, A_CTRL, base | 32'h4, "snap");
`else
      if (base[2]) $display("note: snap base has bit2 set");
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         cyc[s] = 1'b0; stb[s] = 1'b0; we[s] = 1'b0; adr[s] = '0; wdat[s] = '0; ev[s] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      rd(0, A_CTRL, 32'd0, "rst_ctrl");
      rd(0, A_CHEN, 32'd0, "rst_chan_en");
      rd(0, A_OVF,  32'd0, "rst_ovf");
      rd(0, A_C0,   32'd0, "rst_cnt0");
      chk("rst_ovf_any", 64'(ovf[0]), 64'd0);

      // Per-channel enables
      wr(0, A_CTRL, 32'h1, "w_ctrl_en");
      wr(0, A_CHEN, 32'h5, "w_chan_en5");
      pulse(0, 4'hF, 10);
      snap(0, 32'h1);
      rd(0, A_C0,          32'd10, "en_cnt0");
      rd(0, A_C0 + 32'h08, 32'd0,  "en_cnt1");
      rd(0, A_C0 + 32'h10, 32'd10, "en_cnt2");
      rd(0, A_C0 + 32'h18, 32'd0,  "en_cnt3");
      rd(0, A_C0 + 32'h04, 32'd0,  "cnt0_hi_narrow");
      rd(0, A_C0 + 32'h20, 32'd0,  "cnt4_unimpl");
      rd(0, A_CHEN,        32'h5,  "chan_en_rb");
      rd(0, A_CTRL,        32'h1,  "ctrl_rb");

      // Freeze
      wr(0, A_CTRL, 32'h9, "clear_all");
      pulse(0, 4'h1, 5);
      wr(0, A_CTRL, 32'h3, "freeze_on");
      pulse(0, 4'h1, 5);
      snap(0, 32'h3);
      rd(0, A_C0, 32'd5, "frozen_cnt");
      wr(0, A_CTRL, 32'h1, "freeze_off");
      pulse(0, 4'h1, 3);
      snap(0, 32'h1);
      rd(0, A_C0, 32'd8, "thawed_cnt");
      wr(0, A_C0, 32'h55, "w_cnt_ignored");
      snap(0, 32'h1);
      rd(0, A_C0, 32'd8, "cnt_ro");

      // Same-cycle control writes use the old register values
      wr_ev(0, A_CHEN, 32'h0, 4'h1, "chen_off_ev");
      wr_ev(0, A_CHEN, 32'h1, 4'h1, "chen_on_ev");
      wr_ev(0, A_CTRL, 32'h0, 4'h1, "ctrl_off_ev");
      wr_ev(0, A_CTRL, 32'h1, 4'h1, "ctrl_on_ev");
      snap(0, 32'h1);
      rd(0, A_C0, 32'd10, "old_values_cnt");
      rd(0, A_CHEN, 32'h1, "chan_en_rb2");

      // Wrap and sticky overflow
      wr(0, A_CTRL, 32'h9, "clear_all2");
      pulse(0, 4'h1, 257);
      snap(0, 32'h1);
      rd(0, A_C0,  32'd1, "wrap_cnt");
      rd(0, A_OVF, 32'h1, "wrap_ovf");
      chk("wrap_ovf_any", 64'(ovf[0]), 64'd1);
      wr(0, A_CTRL, 32'h9, "clear_keeps_ovf");
      rd(0, A_OVF, 32'h1, "ovf_after_clear");
      rd(0, A_CTRL, 32'h1, "ctrl_pulses_selfclear");
      snap(0, 32'h1);
      rd(0, A_C0, 32'd0, "cnt_after_clear");
      wr(0, A_OVF, 32'h1, "ovf_w1c");
      rd(0, A_OVF, 32'h0, "ovf_cleared");
      chk("ovf_any_cleared", 64'(ovf[0]), 64'd0);
      rd(0, B + 32'hC, 32'd0, "unmapped");
      rd(0, 32'h0000_0000, 32'd0, "out_of_window");

      // Snapshot
      wr(0, A_CTRL, 32'h9, "clear_all3");
      pulse(0, 4'h1, 20);
`ifdef ABACUS_COUNTER_SNAPSHOT_EN
      wr(0, A_CTRL, 32'h5, "snap20");
      pulse(0, 4'h1, 7);
      rd(0, A_C0, 32'd20, "shadow20");
      wr(0, A_CTRL, 32'h5, "snap27");
      rd(0, A_C0, 32'd27, "shadow27");
`else
      pulse(0, 4'h1, 7);
      rd(0, A_C0, 32'd27, "live27");
`endif

      // Saturating instance
      wr(1, A_CTRL, 32'h1, "s_ctrl_en");
      wr(1, A_CHEN, 32'h1, "s_chan_en");
      pulse(1, 4'h1, 257);
      snap(1, 32'h1);
      rd(1, A_C0,  32'hFF, "sat_cnt");
      rd(1, A_OVF, 32'h1,  "sat_ovf");
      chk("sat_ovf_any", 64'(ovf[1]), 64'd1);
      wr_ev(1, A_OVF, 32'h1, 4'h1, "w1c_vs_set");
      rd(1, A_OVF, 32'h1, "set_wins");
      wr(1, A_OVF, 32'h1, "s_ovf_w1c");
      rd(1, A_OVF, 32'h0, "s_ovf_cleared");
      wr_ev(1, A_CTRL, 32'h9, 4'h1, "clear_with_ev");
      rd(1, A_OVF, 32'h0, "clear_ev_no_ovf");
      snap(1, 32'h1);
      rd(1, A_C0, 32'h0, "clear_ev_cnt");
      chk("s_ovf_any_low", 64'(ovf[1]), 64'd0);

      repeat (3) @(posedge clk);
      chk("queues_drained", 64'(qa.size() + qb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
